// File: rtl/bcd_serial_addsub_if.sv
// Handshake bundle for the digit-serial BCD adder/subtractor: operand side and result side.
// The master drives operands and out_ready; the slave (the arithmetic block) drives results and in_ready.
interface bcd_serial_addsub_if #(
    parameter int NDIGITS = 4
);
    localparam int W = 4 * NDIGITS;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         err;

    modport master (
        output in_valid, a, b, sub, cin, out_ready,
        input  in_ready, out_valid, sum, cout, err
    );

    modport slave (
        input  in_valid, a, b, sub, cin, out_ready,
        output in_ready, out_valid, sum, cout, err
    );
endinterface

// File: rtl/bcd_serial_addsub.sv
// Digit-serial packed-BCD add/subtract, one digit per clock LSD first; result valid NDIGITS cycles after accept.
// Result is held in DONE for as long as out_ready stays low; no new operation is accepted until it drains.
module bcd_serial_addsub #(
    parameter int NDIGITS = 4
) (
    input  logic               clk,
    input  logic               rst,
    bcd_serial_addsub_if.slave bus
);
    localparam int              W    = 4 * NDIGITS;
    localparam int              KW   = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam logic [KW-1:0]   LAST = KW'(NDIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic [W-1:0]  r_sum;
    logic          r_sub;
    logic          r_c;
    logic          r_cout;
    logic          r_err;
    logic [KW-1:0] r_k;

    logic          w_accept;
    logic          w_last;
    logic          w_carry;
    logic          w_bad;
    logic [3:0]    w_a_k;
    logic [3:0]    w_b_k;
    logic [3:0]    w_bd;
    logic [3:0]    w_digit;
    logic [4:0]    w_s;

    // Subtraction is A + nines-complement(B) + ~borrow; the final carry then means "no borrow".
    assign w_a_k   = r_a[4*r_k +: 4];
    assign w_b_k   = r_b[4*r_k +: 4];
    assign w_bd    = r_sub ? (4'd9 - w_b_k) : w_b_k;
    assign w_s     = {1'b0, w_a_k} + {1'b0, w_bd} + {4'b0000, r_c};
    assign w_carry = (w_s > 5'd9);
    assign w_digit = w_carry ? (w_s[3:0] + 4'd6) : w_s[3:0];
    assign w_bad   = (w_a_k > 4'd9) || (w_b_k > 4'd9);
    assign w_last  = (r_k == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.in_valid) begin
                    w_accept = 1'b1;
                    w_next   = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_sub  <= 1'b0;
            r_c    <= 1'b0;
            r_k    <= '0;
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a   <= bus.a;
                r_b   <= bus.b;
                r_sub <= bus.sub;
                r_c   <= bus.sub ? ~bus.cin : bus.cin;
                r_k   <= '0;
                r_err <= 1'b0;
            end else if (r_state == S_RUN) begin
                r_sum[4*r_k +: 4] <= w_digit;
                r_c               <= w_carry;
                r_err             <= r_err | w_bad;
                if (w_last) begin
                    r_cout <= w_carry;
                    r_k    <= '0;
                end else begin
                    r_k    <= r_k + KW'(1);
                end
            end
        end
    end

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.sum       = r_sum;
    assign bus.cout      = r_cout;
    assign bus.err       = r_err;
endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Bench for bcd_serial_addsub: a 4-digit and a 1-digit instance, each checked by a queue-based scoreboard
// against a decimal reference model (operands converted to integers, added or subtracted, converted back).
module tb_bcd_serial_addsub;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bcd_serial_addsub_if #(.NDIGITS(4)) bus4 ();
    bcd_serial_addsub_if #(.NDIGITS(1)) bus1 ();

    bcd_serial_addsub #(.NDIGITS(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
    bcd_serial_addsub #(.NDIGITS(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    typedef struct {
        logic [15:0] sum;
        bit          cout;
        bit          err;
        int          acc;
    } exp_t;

    exp_t q4[$];
    exp_t q1[$];

    task automatic chk(input string name, input longint act, input longint req);
        n_chk++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Decimal reference: treats the operands as integers, ignoring digit-serial mechanics.
    task automatic ref_model(input logic [15:0] a, input logic [15:0] b, input bit sub, input bit cin,
                             input int n, output exp_t e);
        longint av = 0, bv = 0, pw = 1, r;
        int d;
        e.err = 1'b0;
        for (int i = 0; i < n; i++) begin
            d = int'(a[4*i +: 4]);
            if (d > 9) e.err = 1'b1;
            av += d * pw;
            d = int'(b[4*i +: 4]);
            if (d > 9) e.err = 1'b1;
            bv += d * pw;
            pw *= 10;
        end
        if (sub) begin
            r = av - bv - longint'(cin);
            e.cout = (r >= 0);
            if (r < 0) r += pw;
        end else begin
            r = av + bv + longint'(cin);
            e.cout = (r >= pw);
            if (e.cout) r -= pw;
        end
        e.sum = '0;
        for (int i = 0; i < n; i++) begin
            e.sum[4*i +: 4] = 4'(r % 10);
            r /= 10;
        end
        e.acc = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one operation and returns just after the accepting edge.
    task automatic issue(input int n, input logic [15:0] a, input logic [15:0] b, input bit sub, input bit cin);
        exp_t e;
        int   w = 0;
        ref_model(a, b, sub, cin, n, e);
        if (n == 4) begin
            bus4.a = a; bus4.b = b; bus4.sub = sub; bus4.cin = cin; bus4.in_valid = 1'b1;
            while (!bus4.in_ready && w < 200) begin step(); w++; end
            chk("in_ready_wait4", bus4.in_ready, 1);
            e.acc = cyc + 1;
            q4.push_back(e);
            step();
            bus4.in_valid = 1'b0;
        end else begin
            bus1.a = a[3:0]; bus1.b = b[3:0]; bus1.sub = sub; bus1.cin = cin; bus1.in_valid = 1'b1;
            while (!bus1.in_ready && w < 200) begin step(); w++; end
            chk("in_ready_wait1", bus1.in_ready, 1);
            e.acc = cyc + 1;
            q1.push_back(e);
            step();
            bus1.in_valid = 1'b0;
        end
    endtask

    function automatic logic [15:0] rnd_bcd(input bit allow_bad);
        logic [15:0] v;
        for (int i = 0; i < 4; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
        if (allow_bad && ($urandom_range(0, 9) == 0)) v[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
        return v;
    endfunction

    bit v4_prev = 1'b0;
    bit v1_prev = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus4.out_valid && !v4_prev) begin
                if (q4.size() == 0) chk("out_valid_unexpected4", bus4.out_valid, 0);
                else chk("latency4", cyc - q4[0].acc, 4);
            end
            if (bus4.out_valid && bus4.out_ready && q4.size() > 0) begin
                if (!q4[0].err) chk("sum4", bus4.sum, q4[0].sum);
                if (!q4[0].err) chk("cout4", bus4.cout, q4[0].cout);
                chk("err4", bus4.err, q4[0].err);
                void'(q4.pop_front());
            end
        end
        v4_prev = bus4.out_valid;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (bus1.out_valid && !v1_prev) begin
                if (q1.size() == 0) chk("out_valid_unexpected1", bus1.out_valid, 0);
                else chk("latency1", cyc - q1[0].acc, 1);
            end
            if (bus1.out_valid && bus1.out_ready && q1.size() > 0) begin
                if (!q1[0].err) chk("sum1", bus1.sum, q1[0].sum[3:0]);
                if (!q1[0].err) chk("cout1", bus1.cout, q1[0].cout);
                chk("err1", bus1.err, q1[0].err);
                void'(q1.pop_front());
            end
        end
        v1_prev = bus1.out_valid;
    end

    initial begin
        int w;
        bus4.in_valid = 1'b0; bus4.a = '0; bus4.b = '0; bus4.sub = 1'b0; bus4.cin = 1'b0; bus4.out_ready = 1'b1;
        bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.sub = 1'b0; bus1.cin = 1'b0; bus1.out_ready = 1'b1;
        rst = 1'b1;
        repeat (3) step();
        chk("rst_out_valid", bus4.out_valid, 0);
        chk("rst_in_ready", bus4.in_ready, 1);
        chk("rst_sum", bus4.sum, 0);
        chk("rst_cout", bus4.cout, 0);
        chk("rst_err", bus4.err, 0);
        rst = 1'b0;
        step();

        // Directed corner cases.
        issue(4, 16'h9999, 16'h0001, 0, 0);
        issue(4, 16'h1234, 16'h0567, 1, 0);
        issue(4, 16'h0000, 16'h0001, 1, 0);
        issue(4, 16'h0500, 16'h0499, 1, 1);
        issue(4, 16'h4999, 16'h5000, 0, 1);
        issue(4, 16'h000A, 16'h0000, 0, 0);
        issue(1, 16'h0009, 16'h0009, 0, 1);
        issue(1, 16'h0000, 16'h0001, 1, 0);

        // Backpressure: result held, no accept while stalled.
        w = 0;
        while (bus4.in_ready == 1'b0 && w < 50) begin step(); w++; end
        bus4.out_ready = 1'b0;
        issue(4, 16'h2468, 16'h1357, 0, 0);
        w = 0;
        while (!bus4.out_valid && w < 50) begin step(); w++; end
        chk("bp_out_valid_seen", bus4.out_valid, 1);
        bus4.a = 16'h1111; bus4.b = 16'h2222; bus4.sub = 1'b1; bus4.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_out_valid", bus4.out_valid, 1);
            chk("bp_in_ready", bus4.in_ready, 0);
            chk("bp_sum", bus4.sum, 16'h3825);
            chk("bp_cout", bus4.cout, 0);
        end
        bus4.in_valid = 1'b0;
        bus4.out_ready = 1'b1;
        step();
        chk("bp_release_in_ready", bus4.in_ready, 1);
        chk("bp_queue_drained", q4.size(), 0);

        // Reset while digit 2 is being processed.
        issue(4, 16'h5555, 16'h4444, 0, 0);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        void'(q4.pop_back());
        for (int i = 0; i < 6; i++) begin
            chk("rst_mid_out_valid", bus4.out_valid, 0);
            chk("rst_mid_in_ready", bus4.in_ready, 1);
            step();
        end
        issue(4, 16'h0001, 16'h0001, 0, 0);

        // Random sweep on both widths, occasional invalid digits and random gaps.
        for (int i = 0; i < 60; i++) begin
            issue(4, rnd_bcd(1), rnd_bcd(1), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 3)) step();
        end
        for (int i = 0; i < 30; i++) begin
            issue(1, rnd_bcd(1) & 16'h000F, rnd_bcd(1) & 16'h000F, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) step();
        end

        w = 0;
        while ((q4.size() != 0 || q1.size() != 0) && w < 200) begin step(); w++; end
        chk("drain4", q4.size(), 0);
        chk("drain1", q1.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
